// File: rtl/aes_uart_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : aes_uart_sequencer
// Description : Sequencer between the UART receive FIFO, an AES core and the
//               UART transmit path. The first block after reset or rekey
//               becomes the key. Each later block is encrypted, and the result
//               is forwarded to the transmitter. Includes a completion
//               watchdog and a processed-block counter.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_uart_sequencer #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx_empty,
   input  logic [127:0]     rx_data,
   output logic             rx_read,
   output logic [127:0]     aes_key,
   output logic [127:0]     aes_block,
   output logic             aes_start,
   input  logic             aes_done,
   input  logic [127:0]     aes_result,
   input  logic             tx_full,
   output logic             tx_write,
   output logic [127:0]     tx_data,
   input  logic             rekey,
   output logic             key_valid,
   output logic             timeout_err,
   output logic [CNT_W-1:0] blk_count
);

   // The watchdog counter gets one spare bit, so the terminal value always fits.
   localparam int              WD_W    = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_REQ  = 3'd1,
      ST_RD_CAP  = 3'd2,
      ST_LAUNCH  = 3'd3,
      ST_BUSY    = 3'd4,
      ST_TX_WAIT = 3'd5
   } state_t;

   state_t          state;
   state_t          state_next;
   logic            rekey_pending;
   logic [WD_W-1:0] wd_count;

   // Datapath enables. They are decoded together with the next state,
   // so that each register update matches its state transition.
   logic            load_key;
   logic            load_block;
   logic            load_result;
   logic            fire_timeout;
   logic            count_tx;

   // State register; an asynchronous reset abandons any block in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and one-cycle strobes. At most one block is in flight.
   always_comb begin
      state_next   = state;
      rx_read      = 1'b0;
      aes_start    = 1'b0;
      tx_write     = 1'b0;
      load_key     = 1'b0;
      load_block   = 1'b0;
      load_result  = 1'b0;
      fire_timeout = 1'b0;
      count_tx     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!rx_empty) begin
               state_next = ST_RD_REQ;
            end
         end
         ST_RD_REQ: begin
            rx_read    = 1'b1;
            state_next = ST_RD_CAP;
         end
         ST_RD_CAP: begin
            // A block that arrives with no key, or after a rekey, is key material.
            if (!key_valid || rekey_pending) begin
               load_key   = 1'b1;
               state_next = ST_IDLE;
            end else begin
               load_block = 1'b1;
               state_next = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            aes_start  = 1'b1;
            state_next = ST_BUSY;
         end
         ST_BUSY: begin
            // A completion in the same cycle as the watchdog limit still wins.
            if (aes_done) begin
               load_result = 1'b1;
               state_next  = ST_TX_WAIT;
            end else if (wd_count == WD_LAST) begin
               fire_timeout = 1'b1;
               state_next   = ST_IDLE;
            end
         end
         ST_TX_WAIT: begin
            if (!tx_full) begin
               tx_write   = 1'b1;
               count_tx   = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Rekey request flag. A new request wins over a clear in the same cycle,
   // so a late rekey is never lost.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rekey_pending <= 1'b0;
      end else if (rekey) begin
         rekey_pending <= 1'b1;
      end else if (load_key) begin
         rekey_pending <= 1'b0;
      end
   end

   // Key register and key-valid flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         aes_key   <= '0;
         key_valid <= 1'b0;
      end else if (load_key) begin
         aes_key   <= rx_data;
         key_valid <= 1'b1;
      end
   end

   // Plaintext register. It is only written in RD_CAP, so it is stable while
   // the core runs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         aes_block <= '0;
      end else if (load_block) begin
         aes_block <= rx_data;
      end
   end

   // Watchdog counter. It is cleared at launch and counts each BUSY cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wd_count <= '0;
      end else if (state == ST_LAUNCH) begin
         wd_count <= '0;
      end else if (state == ST_BUSY) begin
         wd_count <= wd_count + WD_W'(1);
      end
   end

   // Sticky timeout flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         timeout_err <= 1'b0;
      end else if (fire_timeout) begin
         timeout_err <= 1'b1;
      end
   end

   // Result register. It holds its value while the transmitter stalls.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_data <= '0;
      end else if (load_result) begin
         tx_data <= aes_result;
      end
   end

   // Count of blocks handed to the transmitter. It wraps naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         blk_count <= '0;
      end else if (count_tx) begin
         blk_count <= blk_count + CNT_W'(1);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aes_uart_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_uart_sequencer
// Description : Self-checking bench for aes_uart_sequencer. It uses a vector
//               table plus directed multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_uart_sequencer;

   localparam int TO = 16;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          rx_empty = 1'b1;
   logic [127:0]  rx_data = '0;
   logic          rx_read;
   logic [127:0]  aes_key;
   logic [127:0]  aes_block;
   logic          aes_start;
   logic          aes_done = 1'b0;
   logic [127:0]  aes_result = '0;
   logic          tx_full = 1'b0;
   logic          tx_write;
   logic [127:0]  tx_data;
   logic          rekey = 1'b0;
   logic          key_valid;
   logic          timeout_err;
   logic [CW-1:0] blk_count;

   aes_uart_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_empty   (rx_empty),
      .rx_data    (rx_data),
      .rx_read    (rx_read),
      .aes_key    (aes_key),
      .aes_block  (aes_block),
      .aes_start  (aes_start),
      .aes_done   (aes_done),
      .aes_result (aes_result),
      .tx_full    (tx_full),
      .tx_write   (tx_write),
      .tx_data    (tx_data),
      .rekey      (rekey),
      .key_valid  (key_valid),
      .timeout_err(timeout_err),
      .blk_count  (blk_count)
   );

   always #5 clk = ~clk;

   // AES core model: latency 0 means the core never answers. The result is
   // either a fixed value or key XOR block.
   int           model_lat = 1;
   bit           model_fixed_en = 1'b0;
   logic [127:0] model_fixed = '0;
   int           m_rem = 0;
   bit           m_active = 1'b0;
   logic [127:0] m_res = '0;

   always @(posedge clk) begin
      aes_done <= 1'b0;
      if (aes_start) begin
         m_res <= model_fixed_en ? model_fixed : (aes_key ^ aes_block);
         if (model_lat == 1) begin
            aes_done   <= 1'b1;
            aes_result <= model_fixed_en ? model_fixed : (aes_key ^ aes_block);
            m_active   <= 1'b0;
         end else begin
            m_active <= (model_lat != 0);
            m_rem    <= model_lat - 1;
         end
      end else if (m_active) begin
         if (m_rem == 1) begin
            aes_done   <= 1'b1;
            aes_result <= m_res;
            m_active   <= 1'b0;
         end else begin
            m_rem <= m_rem - 1;
         end
      end
   end

   // Strobe monitor: event counts, timestamps and back-to-back strobe detection.
   int           cyc = 0;
   int           rd_cnt = 0;
   int           st_cnt = 0;
   int           tx_cnt = 0;
   int           start_cyc = 0;
   int           tx_cyc = 0;
   int           viol = 0;
   logic [127:0] tx_seen = '0;
   bit           p_rd = 1'b0;
   bit           p_st = 1'b0;
   bit           p_tx = 1'b0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rx_read) rd_cnt <= rd_cnt + 1;
      if (aes_start) begin
         st_cnt    <= st_cnt + 1;
         start_cyc <= cyc;
      end
      if (tx_write) begin
         tx_cnt  <= tx_cnt + 1;
         tx_cyc  <= cyc;
         tx_seen <= tx_data;
      end
      if ((rx_read && p_rd) || (aes_start && p_st) || (tx_write && p_tx)) viol <= viol + 1;
      p_rd <= rx_read;
      p_st <= aes_start;
      p_tx <= tx_write;
   end

   int n_pass  = 0;
   int n_total = 0;
   int push_cyc = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic check_i(input string name, input int got, input int exp);
      n_total++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, exp);
   endtask

   // Offer one block. rx_data is presented in the rx_read cycle and stays valid after it.
   task automatic push(input logic [127:0] d);
      bit got;
      got = 1'b0;
      rx_empty = 1'b0;
      push_cyc = cyc;
      for (int i = 0; i < 20 && !got; i++) begin
         tick();
         if (rx_read) begin
            rx_data  = d;
            rx_empty = 1'b1;
            got      = 1'b1;
         end
      end
      check_i("rx_read_seen", int'(got), 1);
   endtask

   task automatic wait_tx(input int tx0);
      for (int i = 0; i < 100 && tx_cnt == tx0; i++) tick();
      check_i("tx_write_seen", tx_cnt - tx0, 1);
   endtask

   task automatic wait_start(input int st0);
      for (int i = 0; i < 30 && st_cnt == st0; i++) tick();
      check_i("aes_start_seen", st_cnt - st0, 1);
   endtask

   typedef struct {
      int           kind;      // 0 key block, 1 data block, 2 timeout
      logic [127:0] data;
      int           lat;
      bit           fixed_en;
      logic [127:0] fixed;
      logic [127:0] exp;       // expected key (kind 0) or tx_data (kind 1)
      int           exp_cnt;
   } vec_t;

   vec_t vt[5];

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K2 = 128'h0f0e0d0c0b0a09080706050403020100;

   initial begin
      int st0;
      int tx0;
      int rd0;
      int bad;
      logic [127:0] td;

      vt[0] = '{0, K1, 1, 1'b0, '0, K1, 0};
      vt[1] = '{1, 128'h00112233445566778899aabbccddeeff, 10, 1'b1,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1};
      vt[2] = '{1, {16{8'hff}}, 1, 1'b0, '0,
                128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0, 2};
      vt[3] = '{2, {16{8'h11}}, 0, 1'b0, '0, '0, 2};
      vt[4] = '{1, 128'h0123456789abcdef0123456789abcdef, 3, 1'b1,
                {4{32'hcafef00d}}, {4{32'hcafef00d}}, 3};

      #2 reset = 1'b0;
      repeat (3) tick();
      check("rst_rx_read", {127'd0, rx_read}, '0);
      check("rst_aes_start", {127'd0, aes_start}, '0);
      check("rst_tx_write", {127'd0, tx_write}, '0);
      check("rst_key_valid", {127'd0, key_valid}, '0);
      check("rst_timeout", {127'd0, timeout_err}, '0);
      check_i("rst_blk_count", int'(blk_count), 0);
      check("rst_aes_key", aes_key, '0);
      check("rst_aes_block", aes_block, '0);
      check("rst_tx_data", tx_data, '0);
      reset = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) begin
         model_lat      = vt[i].lat;
         model_fixed_en = vt[i].fixed_en;
         model_fixed    = vt[i].fixed;
         st0 = st_cnt;
         tx0 = tx_cnt;
         rd0 = rd_cnt;
         push(vt[i].data);
         case (vt[i].kind)
            0: begin
               repeat (4) tick();
               check("key_valid", {127'd0, key_valid}, 128'd1);
               check("key_value", aes_key, vt[i].exp);
               check_i("key_rd_once", rd_cnt - rd0, 1);
               check_i("key_no_start", st_cnt - st0, 0);
               check_i("key_no_tx", tx_cnt - tx0, 0);
            end
            1: begin
               wait_tx(tx0);
               check("data_block", aes_block, vt[i].data);
               check("data_tx", tx_seen, vt[i].exp);
               check_i("data_cnt", int'(blk_count), vt[i].exp_cnt);
               check_i("data_lat", tx_cyc - start_cyc, vt[i].lat + 1);
            end
            default: begin
               for (int j = 0; j < 60 && !timeout_err; j++) tick();
               check("tout_err", {127'd0, timeout_err}, 128'd1);
               check_i("tout_cycles", cyc - start_cyc, TO + 1);
               repeat (3) tick();
               check_i("tout_cnt", int'(blk_count), vt[i].exp_cnt);
               check_i("tout_no_tx", tx_cnt - tx0, 0);
            end
         endcase
         tick();
      end

      // The result waits for transmitter backpressure.
      tx_full = 1'b1;
      model_lat = 2;
      model_fixed_en = 1'b1;
      model_fixed = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
      st0 = st_cnt;
      tx0 = tx_cnt;
      push(128'h00000000111111112222222233333333);
      wait_start(st0);
      tick();
      tick();
      td = tx_data;
      check("hold_tx_data", td, 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
      bad = 0;
      for (int j = 0; j < 20; j++) begin
         tick();
         if (tx_write || tx_data !== td) bad++;
      end
      check_i("hold_stable", bad, 0);
      check_i("hold_no_tx", tx_cnt - tx0, 0);
      tx_full = 1'b0;
      #1;
      check("hold_release_write", {127'd0, tx_write}, 128'd1);
      tick();
      check_i("hold_cnt", int'(blk_count), 4);
      repeat (3) tick();
      check_i("hold_one_write", tx_cnt - tx0, 1);

      // A rekey during BUSY affects the next block, not the current one.
      model_lat = 5;
      model_fixed_en = 1'b0;
      st0 = st_cnt;
      tx0 = tx_cnt;
      push({16{8'h55}});
      wait_start(st0);
      rekey = 1'b1;
      tick();
      rekey = 1'b0;
      wait_tx(tx0);
      check("rekey_old_key_tx", tx_seen, 128'h55545756515053525d5c5f5e59585b5a);
      check("rekey_key_kept", aes_key, K1);
      tick();
      st0 = st_cnt;
      tx0 = tx_cnt;
      push(K2);
      repeat (4) tick();
      check("rekey_new_key", aes_key, K2);
      check_i("rekey_key_no_start", st_cnt - st0, 0);
      check_i("rekey_key_no_tx", tx_cnt - tx0, 0);
      push({16{8'hff}});
      wait_tx(tx0);
      check("rekey_new_tx", tx_seen, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff);
      check_i("rekey_cnt", int'(blk_count), 6);
      tick();

      // Minimum latency: rx_empty falling to tx_write.
      model_lat = 1;
      tx0 = tx_cnt;
      push('0);
      wait_tx(tx0);
      check_i("min_latency", tx_cyc - push_cyc, 5);
      check("min_lat_tx", tx_seen, K2);
      check_i("min_lat_cnt", int'(blk_count), 7);
      tick();

      // A reset during BUSY abandons the block. The late completion is ignored.
      model_lat = 8;
      st0 = st_cnt;
      push({16{8'h3c}});
      wait_start(st0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      check("mid_rst_key_valid", {127'd0, key_valid}, '0);
      check("mid_rst_timeout", {127'd0, timeout_err}, '0);
      check("mid_rst_strobes", {125'd0, rx_read, aes_start, tx_write}, '0);
      check_i("mid_rst_cnt", int'(blk_count), 0);
      check("mid_rst_key", aes_key, '0);
      check("mid_rst_block", aes_block, '0);
      check("mid_rst_tx_data", tx_data, '0);
      tick();
      tick();
      reset = 1'b1;
      tx0 = tx_cnt;
      st0 = st_cnt;
      repeat (14) tick();
      check_i("post_rst_no_tx", tx_cnt - tx0, 0);
      check_i("post_rst_no_start", st_cnt - st0, 0);
      check_i("post_rst_cnt", int'(blk_count), 0);
      check("post_rst_tx_data", tx_data, '0);
      check("post_rst_key_valid", {127'd0, key_valid}, '0);

      check_i("strobe_gap", viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   // Global watchdog, so the run always ends.
   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "simulation time limit");
   end

endmodule
`default_nettype wire
